// File: rtl/acc_seq.sv
// Command-driven accumulator sequencer that loads operands and steps an external ALU.
// Optional zero/carry flags are built only when ACC_SEQ_FLAGS_EN is defined.
module acc_seq #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_code,
  input  logic [3:0]       cmd_data,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  output logic [3:0]       acc,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);

  localparam logic [1:0] CMD_LOAD_A = 2'b00;
  localparam logic [1:0] CMD_LOAD_B = 2'b01;
  localparam logic [1:0] CMD_EXEC   = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       breg;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;
  assign alu_a  = acc;
  assign alu_b  = breg;
  assign alu_op = op_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (cmd_code == CMD_EXEC) ? ST_EXEC : ST_DONE;
      ST_EXEC: if (cnt_r == '0) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EXEC: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand, opcode and repeat-count registers; acc takes the ALU result once per EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= 4'h0;
      breg  <= 4'h0;
      op_r  <= 3'b000;
      cnt_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_code)
              CMD_LOAD_A: acc <= cmd_data;
              CMD_LOAD_B: breg <= cmd_data;
              CMD_EXEC: begin
                op_r  <= cmd_op;
                cnt_r <= cmd_cnt;
              end
              CMD_CLEAR: begin
                acc  <= 4'h0;
                breg <= 4'h0;
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: begin
          acc <= alu_result;
          if (cnt_r != '0) cnt_r <= cnt_r - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ACC_SEQ_FLAGS_EN
  logic       flag_z_r;
  logic       flag_c_r;
  logic       carry;
  logic [4:0] sum;

  assign sum = {1'b0, acc} + {1'b0, breg};

  always_comb begin
    carry = 1'b0;
    case (op_r)
      3'b010:  carry = sum[4];
      3'b011:  carry = (acc < breg);
      3'b110:  carry = (acc == 4'h0);
      3'b111:  carry = (acc == 4'hf);
      default: carry = 1'b0;
    endcase
  end

  // The zero flag tracks every acc write, so CLEAR leaves it set rather than cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else if (state == ST_EXEC) begin
      flag_z_r <= (alu_result == 4'h0);
      flag_c_r <= carry;
    end else if (accept) begin
      case (cmd_code)
        CMD_LOAD_A: flag_z_r <= (cmd_data == 4'h0);
        CMD_CLEAR: begin
          flag_z_r <= 1'b1;
          flag_c_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign flag_z = flag_z_r;
  assign flag_c = flag_c_r;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 Parameter CNT_W, default 2, width of the repeat count field; EXEC runs cmd_cnt+1 iterations.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_code  input  2  00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 CLEAR.
REQ-007 cmd_data  input  4  operand for LOAD_A/LOAD_B.
REQ-008 cmd_op  input  3  ALU opcode for EXEC.
REQ-009 cmd_cnt  input  CNT_W  repeat count for EXEC.
REQ-010 alu_a  output  4  ALU operand A, driven from acc.
REQ-011 alu_b  output  4  ALU operand B, driven from B register.
REQ-012 alu_op  output  3  ALU opcode, driven from latched op register.
REQ-013 alu_result  input  4  combinational ALU result, same cycle.
REQ-014 acc  output  4  accumulator value.
REQ-015 busy  output  1  high in EXEC and DONE states.
REQ-016 done  output  1  one-cycle pulse when a command completes.
REQ-017 flag_z, flag_c  output  1 each  zero flag; carry/borrow/wrap flag.

Function
REQ-018 FSM states IDLE, EXEC, DONE; cmd_ready = 1 only in IDLE; handshake = cmd_valid & cmd_ready.
REQ-019 IDLE + handshake: LOAD_A -> acc <= cmd_data; LOAD_B -> breg <= cmd_data; CLEAR -> acc, breg <= 0; all three go to DONE.
REQ-020 IDLE + EXEC handshake: op_r <= cmd_op, cnt_r <= cmd_cnt, go to EXEC; unused fields of any command ignored.
REQ-021 Each EXEC cycle: acc <= alu_result; if cnt_r == 0 go to DONE, else cnt_r <= cnt_r - 1 and stay in EXEC.
REQ-022 DONE: done = 1 for exactly that cycle, then IDLE unconditionally.
REQ-023 Latency: LOAD/CLEAR done one cycle after handshake; EXEC with count n done n+2 cycles after handshake; minimum command spacing 2 cycles.
REQ-024 alu_a = acc, alu_b = breg, alu_op = op_r at all times, combinational from registers; op_r holds between commands.
REQ-025 cmd_valid while not IDLE is not accepted; command remaining valid is accepted exactly once on the first IDLE cycle.
REQ-026 Count wraps nothing: cmd_cnt = all-ones runs 2^CNT_W iterations; acc arithmetic is modulo 16 as produced by the ALU.

Reset
REQ-027 rst asserted: immediately acc, breg, op_r, cnt_r, flags = 0, state IDLE, done = 0, busy = 0, cmd_ready = 1, regardless of state (including mid-EXEC).
REQ-028 First handshake possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ACC_SEQ_FLAGS_EN defined: flag_z = (acc == 0) registered with every acc write; flag_c set on each EXEC write per op: 010 carry out of acc+breg, 011 borrow (acc < breg), 110 acc == 0 before write, 111 acc == 15 before write, other ops 0; LOAD_A/LOAD_B leave flag_c unchanged, CLEAR clears both.
REQ-030 Macro undefined: flag logic absent, flag_z and flag_c tied to 0, all other behaviour identical.

Verification
REQ-031 LOAD_A 5, LOAD_B 3, EXEC op 010 cnt 0 -> acc = 8 two cycles after EXEC handshake, done pulse that cycle, flag_c = 0.
REQ-032 acc = 14, EXEC op 111 cnt 3 -> acc sequence 15, 0, 1, 2; final acc = 2, flag_c = 0 (last step), done 5 cycles after handshake, busy high 4 EXEC + 1 DONE cycles.
REQ-033 acc = 2, breg = 3, EXEC op 011 cnt 0 -> acc = 15, flag_c = 1, flag_z = 0; then CLEAR -> acc = 0, flag_z = 1 (flags macro on), flag_c = 0.
REQ-034 rst pulsed during second EXEC iteration -> acc = 0, busy = 0, done = 0, cmd_ready = 1 before next clock edge.
REQ-035 cmd_valid held high with LOAD_B 9 throughout an EXEC cnt 2 -> no acceptance while busy; accepted once on return to IDLE, breg = 9, done one cycle later.
REQ-036 Repeat REQ-031..033 with ACC_SEQ_FLAGS_EN undefined -> identical acc/done timing, flag_z = flag_c = 0 throughout.
